// File: rtl/result_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | result_serializer                                                          |
// | 4-entry result FIFO feeding a start/9-data/even-parity/stop transmitter.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module result_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic [2:0] count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] c_last_tick = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] c_last_bit  = 4'd8;

  state_t     r_state, w_state_next;
  logic [8:0] r_mem [4];
  logic [1:0] r_wr_ptr, r_rd_ptr;
  logic [2:0] r_count;
  logic [7:0] r_timer, w_timer_next;
  logic [3:0] r_bitcnt, w_bitcnt_next;
  logic [8:0] r_shift, w_shift_next;
  logic       r_parity, w_parity_next;
  logic       r_tx, w_tx_next;
  logic       w_push, w_pop, w_bit_end;
  logic [8:0] w_head;

  // in_ready depends only on the registered occupancy
  assign in_ready  = (r_count != 3'd4);
  assign w_push    = in_valid && in_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_bit_end = (r_timer == c_last_tick);
  assign tx        = r_tx;
  assign busy      = (r_state != IDLE);
  assign count     = r_count;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= 8'd0;
      r_bitcnt <= 4'd0;
      r_shift  <= 9'd0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_bitcnt <= w_bitcnt_next;
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
      r_tx     <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_bitcnt_next = r_bitcnt;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_tx_next     = r_tx;
    w_pop         = 1'b0;

    case (r_state)
      IDLE: begin
        w_tx_next = 1'b1;
        if (r_count != 3'd0) begin
          w_pop         = 1'b1;
          w_shift_next  = w_head;
          w_parity_next = ^w_head;
          w_timer_next  = 8'd0;
          w_tx_next     = 1'b0;
          w_state_next  = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_timer_next  = 8'd0;
          w_bitcnt_next = 4'd0;
          w_tx_next     = r_shift[0];
          w_state_next  = DATA;
        end else begin
          w_timer_next = r_timer + 8'd1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_timer_next = 8'd0;
          if (r_bitcnt == c_last_bit) begin
            w_tx_next    = r_parity;
            w_state_next = PARITY;
          end else begin
            // shift out the current bit and present the next one
            w_bitcnt_next = r_bitcnt + 4'd1;
            w_shift_next  = {1'b0, r_shift[8:1]};
            w_tx_next     = r_shift[1];
          end
        end else begin
          w_timer_next = r_timer + 8'd1;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_timer_next = 8'd0;
          w_tx_next    = 1'b1;
          w_state_next = STOP;
        end else begin
          w_timer_next = r_timer + 8'd1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_timer_next = 8'd0;
          // chain straight into the next frame when a word is waiting
          if (r_count != 3'd0) begin
            w_pop         = 1'b1;
            w_shift_next  = w_head;
            w_parity_next = ^w_head;
            w_tx_next     = 1'b0;
            w_state_next  = START;
          end else begin
            w_tx_next    = 1'b1;
            w_state_next = IDLE;
          end
        end else begin
          w_timer_next = r_timer + 8'd1;
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_timer_next = 8'd0;
        w_state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_result_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_result_serializer                                                       |
// | Frame-level model of the serializer compared with the DUT every cycle.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_result_serializer;

  localparam int CPB = 4;
  localparam int FRAME = 12 * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic [8:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  result_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .count    (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line order: start, data LSB first, even parity, stop (bit i = i-th bit period)
  function automatic logic [11:0] frame_of(input logic [8:0] w);
    return {1'b1, ^w, w, 1'b0};
  endfunction

  // Model: word queue plus the frame currently on the line
  logic [8:0]  mq [$];
  logic [11:0] m_bits = 12'hFFF;
  int          m_pos = 0;
  bit          m_active = 1'b0;

  initial forever begin
    int sz;
    @(posedge clock or posedge reset);
    if (reset) begin
      mq.delete();
      m_active = 1'b0;
      m_pos = 0;
    end else begin
      sz = mq.size();
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 1'b0;
      end
      if (!m_active && sz > 0) begin
        m_bits = frame_of(mq.pop_front());
        m_active = 1'b1;
        m_pos = 0;
      end
      if (in_valid && sz != 4) mq.push_back(in_data);
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset !== 1'b1) begin
      chk("tx",       int'(tx),       m_active ? int'(m_bits[m_pos / CPB]) : 1);
      chk("busy",     int'(busy),     int'(m_active));
      chk("count",    int'(count),    mq.size());
      chk("in_ready", int'(in_ready), int'(mq.size() != 4));
    end
  end

  // Line decoder: recovers transmitted words and measures busy time
  logic [8:0]  rx_q [$];
  logic [11:0] fbits = 12'h0;
  int fcyc = 0;
  int busy_cnt = 0;
  int rises = 0;
  bit prev_busy = 1'b0;

  initial forever begin
    @(negedge clock or posedge reset);
    if (reset) begin
      fcyc = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
      if (busy) begin
        busy_cnt++;
        if (fcyc % CPB == CPB / 2) fbits[fcyc / CPB] = tx;
        if (fcyc == FRAME - 1) begin
          rx_q.push_back(fbits[9:1]);
          fcyc = 0;
        end else begin
          fcyc++;
        end
      end
    end
  end

  task automatic chk_rx(input logic [8:0] exp);
    int got;
    got = -1;
    if (rx_q.size() > 0) got = int'(rx_q.pop_front());
    chk("rx_word", got, int'(exp));
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(posedge clock); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] w;
    int b0, r0, waited;
    int cnt_seen [5];
    int exp_cnt [5] = '{1, 1, 2, 3, 4};
    logic [8:0] seq4 [4] = '{9'h001, 9'h002, 9'h004, 9'h100};

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 9'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ready", int'(in_ready), 1);
    reset = 1'b0;
    @(posedge clock); #1;

    // Model frame encodings pinned against hand-worked values
    w = 9'h0A5; chk("frame_0a5", int'(frame_of(w)), 12'h94A);
    w = 9'h1FF; chk("frame_1ff", int'(frame_of(w)), 12'hFFE);
    w = 9'h000; chk("frame_000", int'(frame_of(w)), 12'h800);

    // Single word from idle: popped one edge after the push
    in_valid = 1'b1; in_data = 9'h0A5;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("push_count", int'(count), 1);
    chk("pre_pop_tx", int'(tx), 1);
    @(posedge clock); #1;
    chk("lat_tx", int'(tx), 0);
    chk("lat_busy", int'(busy), 1);
    chk("lat_count", int'(count), 0);
    b0 = busy_cnt;
    wait_idle(100);
    chk("frame_len", busy_cnt - b0, 48);
    chk("end_count", int'(count), 0);
    chk_rx(9'h0A5);

    // All-ones and all-zeros words
    in_valid = 1'b1; in_data = 9'h1FF;
    @(posedge clock); #1;
    in_data = 9'h000;
    @(posedge clock); #1;
    in_valid = 1'b0;
    b0 = busy_cnt;
    wait_idle(200);
    chk("two_frame_len", busy_cnt - b0, 96);
    chk_rx(9'h1FF);
    chk_rx(9'h000);

    // Five consecutive pushes fill the FIFO; held word waits for a slot
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 9'h010 + 9'(i);
      @(posedge clock); #1;
      cnt_seen[i] = int'(count);
    end
    for (int i = 0; i < 5; i++) chk("fill_count", cnt_seen[i], exp_cnt[i]);
    chk("full_ready", int'(in_ready), 0);
    for (int i = 0; i < 10; i++) begin
      in_data = 9'h1E0 + 9'(i);
      @(posedge clock); #1;
      chk("hold_count", int'(count), 4);
      chk("hold_ready", int'(in_ready), 0);
    end
    in_data = 9'h155;
    waited = 10;
    while (!in_ready && waited < 100) begin
      @(posedge clock); #1;
      waited++;
    end
    chk("slot_free_edge", waited, 45);
    chk("after_pop_count", int'(count), 3);
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("sixth_count", int'(count), 4);
    wait_idle(400);
    for (int i = 0; i < 5; i++) chk_rx(9'h010 + 9'(i));
    chk_rx(9'h155);
    chk("no_junk", rx_q.size(), 0);

    // Four queued words go out back to back
    b0 = busy_cnt;
    r0 = rises;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = seq4[i];
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    wait_idle(400);
    chk("burst_len", busy_cnt - b0, 192);
    chk("burst_contig", rises - r0, 1);
    for (int i = 0; i < 4; i++) chk_rx(seq4[i]);

    // Reset in the middle of a frame with three words queued
    in_valid = 1'b1;
    in_data = 9'h000; @(posedge clock); #1;
    in_data = 9'h0F1; @(posedge clock); #1;
    in_data = 9'h0F2; @(posedge clock); #1;
    in_data = 9'h0F3; @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (18) @(posedge clock);
    #1;
    chk("pre_rst_tx", int'(tx), 0);
    chk("pre_rst_count", int'(count), 3);
    reset = 1'b1;
    #1;
    chk("async_tx", int'(tx), 1);
    chk("async_count", int'(count), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_ready", int'(in_ready), 1);
    #1;
    reset = 1'b0;
    rx_q.delete();
    r0 = rises;
    repeat (60) @(posedge clock);
    #1;
    chk("no_frames", rises - r0, 0);
    chk("rx_empty", rx_q.size(), 0);

    // First push after reset
    in_valid = 1'b1; in_data = 9'h0A5;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_tx", int'(tx), 0);
    chk("post_rst_busy", int'(busy), 1);
    wait_idle(100);
    chk_rx(9'h0A5);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
